// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave bank: N_REGS byte-writable control words plus N_STATUS read-only status words.
// Latency: a hit in cycle 0 gives Sl_xferAck/Sl_DBus in cycle 1; ack never asserts two cycles running.
// No backpressure or retry; define OPB_REG_SHADOW_EN for shadow registers with an atomic COMMIT word.
module opb_register_bank_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR   = 32'h01060900,
  parameter logic [31:0] C_HIGHADDR   = 32'h010609FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          N_REGS       = 4,
  parameter int          N_STATUS     = 2,
  parameter logic [31:0] C_RESET_VAL  = 32'h00000000
) (
  input  logic                     OPB_Clk,
  input  logic                     OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1]  OPB_ABus,
  input  logic [0:3]               OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]  OPB_DBus,
  input  logic                     OPB_RNW,
  input  logic                     OPB_select,
  input  logic                     OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]  Sl_DBus,
  output logic                     Sl_errAck,
  output logic                     Sl_retry,
  output logic                     Sl_toutSup,
  output logic                     Sl_xferAck,
  output logic [N_REGS*32-1:0]     user_data_out,
  output logic [N_REGS-1:0]        user_wr_strobe,
  input  logic [N_STATUS*32-1:0]   user_data_in
);

  // Word index of the COMMIT register (only decoded in the shadow build).
  localparam int COMMIT_IDX = N_REGS + N_STATUS;

  // OPB numbers bits MSB-first, so a straight assignment puts DBus[k] on bit 31-k
  // and BE[0] (DBus[0:7]) on be[3] (bits 31:24).
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] offset;
  logic [29:0] idx;
  logic        in_window;
  logic        hit;
  logic        wr_hit;
  logic        rd_hit;

  logic              ack_q;
  logic [31:0]       rdata_q, rdata_d;
  logic [N_REGS-1:0] strobe_q, strobe_d;
  logic [31:0]       ctrl_q [N_REGS];
  logic [31:0]       ctrl_d [N_REGS];

`ifdef OPB_REG_SHADOW_EN
  logic [31:0]       out_q [N_REGS];
  logic [31:0]       out_d [N_REGS];
  logic [N_REGS-1:0] pend_q, pend_d;
  logic              commit;
`endif

  logic unused_ok;

  assign addr   = OPB_ABus;
  assign wdata  = OPB_DBus;
  assign be     = OPB_BE;
  assign offset = addr - C_BASEADDR;
  assign idx    = offset[31:2];

  // Sequential-address hint and the byte offset within a word carry no meaning here.
  assign unused_ok = ^{OPB_seqAddr, offset[1:0]};

  assign in_window = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  // ack_q masks the ack cycle so a held select re-hits only every other cycle.
  assign hit    = OPB_select && in_window && !ack_q;
  assign wr_hit = hit && !OPB_RNW;
  assign rd_hit = hit && OPB_RNW;

`ifdef OPB_REG_SHADOW_EN
  // Commit fires on a write to the COMMIT word with DBus[31] (bit 0) enabled and set.
  assign commit = wr_hit && (idx == 30'(COMMIT_IDX)) && be[0] && wdata[0];
`endif

  // Merge the enabled bytes of a write into the old word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  en);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (en[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  // Next-state decode: register writes, strobes, read mux, shadow commit.
  always_comb begin
    ctrl_d   = ctrl_q;
    strobe_d = '0;
    rdata_d  = '0;
`ifdef OPB_REG_SHADOW_EN
    out_d    = out_q;
    pend_d   = pend_q;
`endif
    for (int i = 0; i < N_REGS; i++) begin
      if (wr_hit && (idx == 30'(i))) begin
        ctrl_d[i] = merge_bytes(ctrl_q[i], wdata, be);
`ifdef OPB_REG_SHADOW_EN
        pend_d[i] = 1'b1;
`else
        // Strobe even with all byte enables low: software asked for a pulse.
        strobe_d[i] = 1'b1;
`endif
      end
      if (rd_hit && (idx == 30'(i))) rdata_d = ctrl_q[i];
    end
    for (int j = 0; j < N_STATUS; j++) begin
      if (rd_hit && (idx == 30'(N_REGS + j))) rdata_d = user_data_in[32*j +: 32];
    end
`ifdef OPB_REG_SHADOW_EN
    if (commit) begin
      out_d    = ctrl_q;
      strobe_d = pend_q;
      pend_d   = '0;
    end
    if (rd_hit && (idx == 30'(COMMIT_IDX))) rdata_d[N_REGS-1:0] = pend_q;
`endif
  end

  // Bus-side state and control (or shadow) registers.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      strobe_q <= '0;
      for (int i = 0; i < N_REGS; i++) ctrl_q[i] <= C_RESET_VAL;
    end else begin
      ack_q    <= hit;
      rdata_q  <= rdata_d;
      strobe_q <= strobe_d;
      for (int i = 0; i < N_REGS; i++) ctrl_q[i] <= ctrl_d[i];
    end
  end

`ifdef OPB_REG_SHADOW_EN
  // Committed outputs and the written-since-last-commit mask.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      pend_q <= '0;
      for (int i = 0; i < N_REGS; i++) out_q[i] <= C_RESET_VAL;
    end else begin
      pend_q <= pend_d;
      for (int i = 0; i < N_REGS; i++) out_q[i] <= out_d[i];
    end
  end
`endif

  for (genvar gi = 0; gi < N_REGS; gi++) begin : g_out
`ifdef OPB_REG_SHADOW_EN
    assign user_data_out[32*gi +: 32] = out_q[gi];
`else
    assign user_data_out[32*gi +: 32] = ctrl_q[gi];
`endif
  end

  // rdata_q is only loaded on a read hit, so it is zero outside the ack cycle.
  assign Sl_DBus        = rdata_q;
  assign Sl_xferAck     = ack_q;
  assign user_wr_strobe = strobe_q;
  assign Sl_errAck      = 1'b0;
  assign Sl_retry       = 1'b0;
  assign Sl_toutSup     = 1'b0;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
module tb_opb_register_bank_ppc2simulink;

  localparam logic [31:0] RV  = 32'hA5A5A5A5;
  localparam logic [127:0] ALL_RV = {RV, RV, RV, RV};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [0:31]   abus = '0;
  logic [0:3]    be = '0;
  logic [0:31]   dbus = '0;
  logic          rnw = 1'b1;
  logic          sel = 1'b0;
  logic          seq = 1'b0;
  logic [0:31]   sl_dbus;
  logic          sl_erracq, sl_retry, sl_tout, sl_ack;
  logic [127:0]  udo;
  logic [3:0]    strb;
  logic [63:0]   udi = '0;

  int n_tests = 0;
  int n_fail  = 0;

  logic         ack_s;
  logic [31:0]  rd_s;
  logic [3:0]   strb_s;
  logic [127:0] udo_s;

  opb_register_bank_ppc2simulink #(
    .C_RESET_VAL(32'hA5A5A5A5)
  ) dut (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be),
    .OPB_DBus(dbus), .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq),
    .Sl_DBus(sl_dbus), .Sl_errAck(sl_erracq), .Sl_retry(sl_retry),
    .Sl_toutSup(sl_tout), .Sl_xferAck(sl_ack),
    .user_data_out(udo), .user_wr_strobe(strb), .user_data_in(udi)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // One transfer: present in cycle 0, capture the cycle-1 outputs, then drop select.
  task automatic xfer(input logic [31:0] a, input logic [0:3] b, input logic [31:0] d, input logic r);
    @(negedge clk);
    abus = a; be = b; dbus = d; rnw = r; sel = 1'b1;
    @(negedge clk);
    ack_s = sl_ack; rd_s = sl_dbus; strb_s = strb; udo_s = udo;
    sel = 1'b0; abus = '0; be = '0; dbus = '0; rnw = 1'b1;
  endtask

  // Cycle after an ack: bus quiet, strobes low.
  task automatic idle_check(input string tag);
    @(negedge clk);
    check({tag, "_ack_idle"}, 128'(sl_ack), 128'(1'b0));
    check({tag, "_dbus_idle"}, 128'(sl_dbus), 128'(0));
    check({tag, "_strb_idle"}, 128'(strb), 128'(0));
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_ack", 128'(sl_ack), 128'(1'b0));
    check("rst_dbus", 128'(sl_dbus), 128'(0));
    check("rst_udo", udo, ALL_RV);
    check("rst_strb", 128'(strb), 128'(0));
    check("rst_ties", 128'({sl_erracq, sl_retry, sl_tout}), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Status words
    udi = {32'hDEADBEEF, 32'hCAFEF00D};
    xfer(32'h01060914, 4'b1111, 32'h0, 1'b1);
    check("st1_ack", 128'(ack_s), 128'(1'b1));
    check("st1_rd", 128'(rd_s), 128'(32'hDEADBEEF));
    idle_check("st1");
    xfer(32'h01060910, 4'b1111, 32'h0, 1'b1);
    check("st0_rd", 128'(rd_s), 128'(32'hCAFEF00D));
    xfer(32'h01060914, 4'b1111, 32'h12345678, 1'b0);
    check("stw_ack", 128'(ack_s), 128'(1'b1));
    check("stw_strb", 128'(strb_s), 128'(0));
    check("stw_udo", udo_s, ALL_RV);
    xfer(32'h01060914, 4'b1111, 32'h0, 1'b1);
    check("stw_rd", 128'(rd_s), 128'(32'hDEADBEEF));

    // Unmapped in-window word (index 7)
    xfer(32'h0106091C, 4'b1111, 32'h0, 1'b1);
    check("unm_ack", 128'(ack_s), 128'(1'b1));
    check("unm_rd", 128'(rd_s), 128'(0));
    xfer(32'h0106091C, 4'b1111, 32'hFFFFFFFF, 1'b0);
    check("unmw_strb", 128'(strb_s), 128'(0));
    check("unmw_udo", udo_s, ALL_RV);

    // Out-of-window addresses
    xfer(32'h01060A00, 4'b1111, 32'h0, 1'b1);
    check("oow_hi_ack", 128'(ack_s), 128'(1'b0));
    check("oow_hi_dbus", 128'(rd_s), 128'(0));
    xfer(32'h010608FC, 4'b1111, 32'h11111111, 1'b0);
    check("oow_lo_ack", 128'(ack_s), 128'(1'b0));
    check("oow_lo_udo", udo_s, ALL_RV);
    idle_check("oow");

    // Select held for six cycles on a status read: ack 0,1,0,1,0,1
    @(negedge clk);
    abus = 32'h01060914; rnw = 1'b1; be = 4'b1111; sel = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("hold_ack", 128'(sl_ack), 128'(i % 2));
      check("hold_dbus", 128'(sl_dbus), (i % 2 == 1) ? 128'(32'hDEADBEEF) : 128'(0));
      @(negedge clk);
    end
    sel = 1'b0;
    @(negedge clk);

    // Reset mid-transfer: ack drops at once, writes under reset do not land
    @(negedge clk);
    abus = 32'h01060914; rnw = 1'b1; sel = 1'b1;
    @(negedge clk);
    check("mid_ack_before", 128'(sl_ack), 128'(1'b1));
    rst_n = 1'b0;
    #1;
    check("mid_ack_drop", 128'(sl_ack), 128'(1'b0));
    check("mid_dbus_drop", 128'(sl_dbus), 128'(0));
    sel = 1'b0;
    @(negedge clk);
    abus = 32'h01060900; dbus = 32'h11111111; be = 4'b1111; rnw = 1'b0; sel = 1'b1;
    @(negedge clk);
    check("rstw_udo", udo, ALL_RV);
    check("rstw_ack", 128'(sl_ack), 128'(1'b0));
    sel = 1'b0; rnw = 1'b1; dbus = '0;
    rst_n = 1'b1;
    idle_check("rel");

`ifdef OPB_REG_SHADOW_EN
    // Shadow writes do not reach the outputs until COMMIT
    xfer(32'h01060900, 4'b1111, 32'h00000001, 1'b0);
    check("sh_w0_ack", 128'(ack_s), 128'(1'b1));
    check("sh_w0_strb", 128'(strb_s), 128'(0));
    check("sh_w0_udo", udo_s, ALL_RV);
    xfer(32'h01060908, 4'b1111, 32'h00000002, 1'b0);
    check("sh_w2_udo", udo_s, ALL_RV);
    xfer(32'h01060918, 4'b1111, 32'h0, 1'b1);
    check("sh_pend", 128'(rd_s), 128'(32'h5));
    xfer(32'h01060900, 4'b1111, 32'h0, 1'b1);
    check("sh_rb0", 128'(rd_s), 128'(32'h1));
    xfer(32'h01060918, 4'b1111, 32'h00000001, 1'b0);
    check("sh_commit_udo", udo_s, {RV, 32'h2, RV, 32'h1});
    check("sh_commit_strb", 128'(strb_s), 128'(4'b0101));
    idle_check("sh_commit");
    xfer(32'h01060918, 4'b1111, 32'h0, 1'b1);
    check("sh_pend_clr", 128'(rd_s), 128'(0));
    xfer(32'h01060918, 4'b1111, 32'h00000001, 1'b0);
    check("sh_empty_strb", 128'(strb_s), 128'(0));
    check("sh_empty_udo", udo_s, {RV, 32'h2, RV, 32'h1});
`else
    // Direct full-word write to register 1
    xfer(32'h01060904, 4'b1111, 32'h12345678, 1'b0);
    check("w1_ack", 128'(ack_s), 128'(1'b1));
    check("w1_udo", udo_s, {RV, RV, 32'h12345678, RV});
    check("w1_strb", 128'(strb_s), 128'(4'b0010));
    idle_check("w1");
    xfer(32'h01060904, 4'b1111, 32'h0, 1'b1);
    check("r1_rd", 128'(rd_s), 128'(32'h12345678));
    idle_check("r1");
    // Only OPB_BE[2] set: DBus[16:23] lands in bits 15:8
    xfer(32'h01060904, 4'b0010, 32'hFFFFFFFF, 1'b0);
    check("be2_udo", udo_s, {RV, RV, 32'h1234FF78, RV});
    check("be2_strb", 128'(strb_s), 128'(4'b0010));
    // No byte enables: value holds, strobe still pulses
    xfer(32'h01060904, 4'b0000, 32'h00000000, 1'b0);
    check("be0_udo", udo_s, {RV, RV, 32'h1234FF78, RV});
    check("be0_strb", 128'(strb_s), 128'(4'b0010));
    // Last register, top byte only (OPB_BE[0] -> bits 31:24)
    xfer(32'h0106090C, 4'b1000, 32'h3C000000, 1'b0);
    check("w3_udo", udo_s, {32'h3CA5A5A5, RV, 32'h1234FF78, RV});
    check("w3_strb", 128'(strb_s), 128'(4'b1000));
    // COMMIT index is plain unmapped space here
    xfer(32'h01060918, 4'b1111, 32'hFFFFFFFF, 1'b0);
    check("cm_strb", 128'(strb_s), 128'(0));
    check("cm_udo", udo_s, {32'h3CA5A5A5, RV, 32'h1234FF78, RV});
    xfer(32'h01060918, 4'b1111, 32'h0, 1'b1);
    check("cm_rd", 128'(rd_s), 128'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
